// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester IDs
// and the supported read-latency range.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_C = 1'b0;
    localparam req_id_t REQ_D = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 2;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last
// wins; the pointer follows every grant issued while enabled.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    req_id_t    r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                w_gnt = (r_last == REQ_C) ? 2'b10 : 2'b01;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    // Reset to "debug granted last" so the core wins the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= REQ_D;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1] ? REQ_D : REQ_C;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/dmem_arb.sv
// Data-memory arbiter between the core MEM stage and a debug/DMA port.
// Writes complete in the grant cycle; reads block new grants until rdata returns.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_c_req,
    input  logic        i_c_wen,
    input  logic [31:0] i_c_addr,
    input  logic [31:0] i_c_wdata,
    input  logic [3:0]  i_c_mask,
    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_c_gnt,
    output logic        o_d_gnt,
    output logic        o_c_rvld,
    output logic        o_d_rvld,
    output logic [31:0] o_c_rdata,
    output logic [31:0] o_d_rdata,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("dmem_arb: RD_LAT out of range");
    end

    // RD_LAT=4 truncates to 0; the counter then wraps 0->3->2->1, still four cycles.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    req_id_t          r_owner, w_owner_nxt;

    logic       w_en;
    logic [1:0] w_gnt;
    logic       w_any_gnt;
    req_id_t    w_win;
    logic       w_win_wen;
    logic       w_rvld;

    // Reset gates grants combinationally so strobes drop the moment it asserts.
    assign w_en = (r_state == ST_IDLE) & ~i_rst;

    rr_arb2 u_rr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req ({i_d_req, i_c_req}),
        .i_en  (w_en),
        .o_gnt (w_gnt)
    );

    assign w_any_gnt = |w_gnt;
    assign w_win     = w_gnt[1] ? REQ_D : REQ_C;
    assign w_win_wen = (w_win == REQ_D) ? i_d_wen : i_c_wen;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= REQ_C;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_any_gnt && !w_win_wen) begin
                    w_state_nxt = ST_RD_WAIT;
                    w_cnt_nxt   = LAT_LOAD;
                    w_owner_nxt = w_win;
                end
            end
            ST_RD_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rvld = (r_state == ST_RD_WAIT) && (r_cnt == CNT_W'(1));

    always_comb begin
        o_dmem_addr  = '0;
        o_dmem_wdata = '0;
        o_dmem_mask  = '0;
        o_dmem_ren   = 1'b0;
        o_dmem_wen   = 1'b0;
        if (w_any_gnt) begin
            o_dmem_addr = (w_win == REQ_D) ? i_d_addr : i_c_addr;
            o_dmem_mask = (w_win == REQ_D) ? i_d_mask : i_c_mask;
            if (w_win_wen) begin
                o_dmem_wen   = 1'b1;
                o_dmem_wdata = (w_win == REQ_D) ? i_d_wdata : i_c_wdata;
            end else begin
                o_dmem_ren = 1'b1;
            end
        end
    end

    assign o_c_gnt   = w_gnt[0];
    assign o_d_gnt   = w_gnt[1];
    assign o_c_rvld  = w_rvld && (r_owner == REQ_C);
    assign o_d_rvld  = w_rvld && (r_owner == REQ_D);
    assign o_c_rdata = o_c_rvld ? i_dmem_rdata : '0;
    assign o_d_rdata = o_d_rvld ? i_dmem_rdata : '0;
    assign o_stall   = i_c_req & ~w_gnt[0];

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: two instances (RD_LAT=1 and RD_LAT=3) checked every cycle
// against a transaction-level model, plus directed scenarios.
module tb_dmem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        c_req   [2];
    logic        c_wen   [2];
    logic [31:0] c_addr  [2];
    logic [31:0] c_wdata [2];
    logic [3:0]  c_mask  [2];
    logic        d_req   [2];
    logic        d_wen   [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [3:0]  d_mask  [2];
    logic [31:0] mrd     [2];

    logic        c_gnt   [2];
    logic        d_gnt   [2];
    logic        c_rvld  [2];
    logic        d_rvld  [2];
    logic [31:0] c_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_mask  [2];
    logic        m_ren   [2];
    logic        m_wen   [2];
    logic        stall   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arb #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst[g]),
            .i_c_req      (c_req[g]),
            .i_c_wen      (c_wen[g]),
            .i_c_addr     (c_addr[g]),
            .i_c_wdata    (c_wdata[g]),
            .i_c_mask     (c_mask[g]),
            .i_d_req      (d_req[g]),
            .i_d_wen      (d_wen[g]),
            .i_d_addr     (d_addr[g]),
            .i_d_wdata    (d_wdata[g]),
            .i_d_mask     (d_mask[g]),
            .o_c_gnt      (c_gnt[g]),
            .o_d_gnt      (d_gnt[g]),
            .o_c_rvld     (c_rvld[g]),
            .o_d_rvld     (d_rvld[g]),
            .o_c_rdata    (c_rdata[g]),
            .o_d_rdata    (d_rdata[g]),
            .o_dmem_addr  (m_addr[g]),
            .o_dmem_wdata (m_wdata[g]),
            .o_dmem_mask  (m_mask[g]),
            .o_dmem_ren   (m_ren[g]),
            .o_dmem_wen   (m_wen[g]),
            .i_dmem_rdata (mrd[g]),
            .o_stall      (stall[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: cycle at which an outstanding read returns, its owner,
    // and who was granted last (1 = debug).
    int   m_ret  [2];
    logic m_own  [2];
    logic m_last [2];
    logic m_gc   [2];
    logic m_gd   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic void model_reset(input int k);
        m_ret[k]  = -1;
        m_own[k]  = 1'b0;
        m_last[k] = 1'b1;
        m_gc[k]   = 1'b0;
        m_gd[k]   = 1'b0;
    endfunction

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic gc, gd, rc, rd, ren, wen, win, wr;
            logic [31:0] a, wd;
            logic [3:0]  m;
            string p;
            gc = 0; gd = 0; rc = 0; rd = 0; ren = 0; wen = 0; win = 0; wr = 0;
            a = 0; wd = 0; m = 0;
            p = $sformatf("L%0d ", lat_of(k));
            if (rst[k]) begin
                model_reset(k);
            end else begin
                rc = (m_ret[k] == cyc) && !m_own[k];
                rd = (m_ret[k] == cyc) && m_own[k];
                if (m_ret[k] < cyc && (c_req[k] || d_req[k])) begin
                    win = (c_req[k] && d_req[k]) ? !m_last[k] : d_req[k];
                    gc  = !win;
                    gd  = win;
                    wr  = win ? d_wen[k] : c_wen[k];
                    a   = win ? d_addr[k] : c_addr[k];
                    m   = win ? d_mask[k] : c_mask[k];
                    if (wr) begin
                        wen = 1;
                        wd  = win ? d_wdata[k] : c_wdata[k];
                    end else begin
                        ren      = 1;
                        m_ret[k] = cyc + lat_of(k);
                        m_own[k] = win;
                    end
                    m_last[k] = win;
                end
            end
            chk({p, "c_gnt"},   32'(c_gnt[k]),  32'(gc));
            chk({p, "d_gnt"},   32'(d_gnt[k]),  32'(gd));
            chk({p, "c_rvld"},  32'(c_rvld[k]), 32'(rc));
            chk({p, "d_rvld"},  32'(d_rvld[k]), 32'(rd));
            chk({p, "c_rdata"}, c_rdata[k], rc ? mrd[k] : 32'h0);
            chk({p, "d_rdata"}, d_rdata[k], rd ? mrd[k] : 32'h0);
            chk({p, "ren"},     32'(m_ren[k]),  32'(ren));
            chk({p, "wen"},     32'(m_wen[k]),  32'(wen));
            chk({p, "addr"},    m_addr[k], a);
            chk({p, "wdata"},   m_wdata[k], wd);
            chk({p, "mask"},    32'(m_mask[k]), 32'(m));
            chk({p, "stall"},   32'(stall[k]),  32'(c_req[k] && !gc));
            m_gc[k] = gc;
            m_gd[k] = gd;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic set_c(input int k, input logic req, input logic wen,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        c_req[k] = req; c_wen[k] = wen; c_addr[k] = addr; c_wdata[k] = wdata; c_mask[k] = mask;
    endtask

    task automatic set_d(input int k, input logic req, input logic wen,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        d_req[k] = req; d_wen[k] = wen; d_addr[k] = addr; d_wdata[k] = wdata; d_mask[k] = mask;
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < 2; k++) begin
            if (!(c_req[k] && !m_gc[k] && $urandom_range(9) != 0)) begin
                set_c(k, $urandom_range(2) != 0, 1'($urandom_range(1)),
                      $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(15)));
            end
            if (!(d_req[k] && !m_gd[k] && $urandom_range(9) != 0)) begin
                set_d(k, $urandom_range(2) != 0, 1'($urandom_range(1)),
                      $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(15)));
            end
            mrd[k] = $urandom;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            set_c(k, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
            set_d(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            mrd[k] = 32'h0;
            model_reset(k);
        end
        @(posedge clk);
        #1;

        // Reset state with the core requesting: no grant, stall follows c_req.
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            set_c(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        cycle();

        // Core masked write, debug idle.
        set_c(0, 1'b1, 1'b1, 32'h204, 32'h0000_ABCD, 4'b0011);
        sample();
        chk("w36 c_gnt", 32'(c_gnt[0]), 32'd1);
        chk("w36 wen",   32'(m_wen[0]), 32'd1);
        chk("w36 mask",  32'(m_mask[0]), 32'h3);
        chk("w36 addr",  m_addr[0], 32'h204);
        chk("w36 wdata", m_wdata[0], 32'h0000_ABCD);
        advance();

        // Core read, RD_LAT=1.
        set_c(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        mrd[0] = 32'hDEAD_BEEF;
        sample();
        chk("r32 c_gnt", 32'(c_gnt[0]), 32'd1);
        chk("r32 ren",   32'(m_ren[0]), 32'd1);
        chk("r32 addr",  m_addr[0], 32'h100);
        advance();
        set_c(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        chk("r32 c_rvld",  32'(c_rvld[0]), 32'd1);
        chk("r32 c_rdata", c_rdata[0], 32'hDEAD_BEEF);
        chk("r32 d_rvld",  32'(d_rvld[0]), 32'd0);
        advance();

        // Both write every cycle from reset: c,d,c,d.
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        set_c(0, 1'b1, 1'b1, 32'h1000, 32'hC000_0000, 4'hF);
        set_d(0, 1'b1, 1'b1, 32'h2000, 32'hD000_0000, 4'hF);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("ww33 c_gnt", 32'(c_gnt[0]), 32'(i % 2 == 0));
            chk("ww33 d_gnt", 32'(d_gnt[0]), 32'(i % 2 == 1));
            chk("ww33 wen",   32'(m_wen[0]), 32'd1);
            chk("ww33 stall", 32'(stall[0]), 32'(i % 2 == 1));
            advance();
            if (m_gc[0]) set_c(0, 1'b1, 1'b1, 32'h1004 + 32'(4 * i), 32'hC000_0001 + 32'(i), 4'hF);
            if (m_gd[0]) set_d(0, 1'b1, 1'b1, 32'h2004 + 32'(4 * i), 32'hD000_0001 + 32'(i), 4'hF);
        end
        set_c(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // RD_LAT=3: core write first so the debug port wins the next contention.
        set_c(1, 1'b1, 1'b1, 32'h300, 32'h55, 4'hF);
        cycle();
        set_c(1, 1'b1, 1'b1, 32'h304, 32'h66, 4'hF);
        set_d(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        mrd[1] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i == 0) chk("r34 d_gnt", 32'(d_gnt[1]), 32'd1);
            if (i < 4) begin
                chk("r34 c_gnt", 32'(c_gnt[1]), 32'd0);
                chk("r34 stall", 32'(stall[1]), 32'd1);
            end else begin
                chk("r34 c_gnt late", 32'(c_gnt[1]), 32'd1);
            end
            chk("r34 d_rvld", 32'(d_rvld[1]), 32'(i == 3));
            advance();
            if (i == 0) set_d(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        set_c(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();

        // Reset pulse inside a RD_LAT=3 read must kill its return.
        set_d(1, 1'b1, 1'b0, 32'h404, 32'h0, 4'hF);
        sample();
        chk("r35 d_gnt", 32'(d_gnt[1]), 32'd1);
        advance();
        set_d(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_c(1, 1'b1, 1'b1, 32'h308, 32'h77, 4'hF);
        rst[1] = 1'b1;
        #1;
        chk("r35 rst c_gnt", 32'(c_gnt[1]), 32'd0);
        chk("r35 rst ren",   32'(m_ren[1]), 32'd0);
        chk("r35 rst wen",   32'(m_wen[1]), 32'd0);
        chk("r35 rst addr",  m_addr[1], 32'h0);
        chk("r35 rst rvld",  32'(d_rvld[1]), 32'd0);
        model_reset(1);
        rst[1] = 1'b0;
        cycle();
        set_c(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        sample();
        chk("r35 no d_rvld", 32'(d_rvld[1]), 32'd0);
        advance();

        // Randomized traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
